// File: rtl/proc_control_fsm.sv
// proc_control_fsm: fetch/decode/execute sequencer for the 16-bit processor,
// with an optional single-step gate on instruction fetch.
`default_nettype none

module proc_control_fsm #(
  parameter int D_AW   = 8,
  parameter int RF_AW  = 4,
  parameter int ALU_SW = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       IR,
  input  logic              StepEn,
  input  logic              Step,
  output logic              PC_Clr,
  output logic              PC_Up,
  output logic              IR_Ld,
  output logic [D_AW-1:0]   D_Addr,
  output logic              D_Wr,
  output logic              RF_s,
  output logic [RF_AW-1:0]  RF_W_Addr,
  output logic              RF_W_En,
  output logic [RF_AW-1:0]  RF_Ra_Addr,
  output logic [RF_AW-1:0]  RF_Rb_Addr,
  output logic [ALU_SW-1:0] ALU_s,
  output logic              Halted,
  output logic [3:0]        State,
  output logic [3:0]        NextState
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [ALU_SW-1:0] C_ALU_ADD = ALU_SW'(1);
  localparam logic [ALU_SW-1:0] C_ALU_SUB = ALU_SW'(2);

  state_t state_q, state_d;
  logic   step_s1_q, step_s2_q, step_s3_q;
  logic   step_pulse;
  logic   go;

  assign step_pulse = step_s2_q & ~step_s3_q;
  assign go         = ~StepEn | step_pulse;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_INIT;
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_s1_q <= Step;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
    end
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (IR[15:12])
          4'd1:    state_d = S_LOAD_A;
          4'd2:    state_d = S_STORE;
          4'd3:    state_d = S_ADD;
          4'd4:    state_d = S_SUB;
          4'd5:    state_d = S_HALT;
          default: state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // While Reset is low the state sits in INIT, so PC_Clr is held off until release.
  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_En    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s      = '0;
    Halted     = 1'b0;
    case (state_q)
      S_INIT:  PC_Clr = Reset;
      S_FETCH: begin
        IR_Ld = go;
        PC_Up = go;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = IR[4 +: D_AW];
        RF_s      = 1'b1;
        RF_W_Addr = IR[0 +: RF_AW];
        RF_W_En   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        D_Addr     = IR[4 +: D_AW];
        RF_Ra_Addr = IR[0 +: RF_AW];
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = IR[8 +: RF_AW];
        RF_Rb_Addr = IR[4 +: RF_AW];
        RF_W_Addr  = IR[0 +: RF_AW];
        RF_W_En    = 1'b1;
        ALU_s      = (state_q == S_ADD) ? C_ALU_ADD : C_ALU_SUB;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign State     = state_q;
  assign NextState = Reset ? state_d : S_INIT;

endmodule

`default_nettype wire

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm: directed and random instructions
// against a table-driven reference model, plus single-step, reset and halt scenarios.
`default_nettype none

module tb_proc_control_fsm;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        StepEn = 1'b0;
  logic        Step = 1'b0;

  logic       PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_En, Halted;
  logic [7:0] D_Addr;
  logic [3:0] RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State, NextState;
  logic [2:0] ALU_s;

  proc_control_fsm #(.D_AW(8), .RF_AW(4), .ALU_SW(3)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .StepEn(StepEn), .Step(Step),
    .PC_Clr(PC_Clr), .PC_Up(PC_Up), .IR_Ld(IR_Ld), .D_Addr(D_Addr), .D_Wr(D_Wr),
    .RF_s(RF_s), .RF_W_Addr(RF_W_Addr), .RF_W_En(RF_W_En), .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr), .ALU_s(ALU_s), .Halted(Halted), .State(State),
    .NextState(NextState)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pc_clr, pc_up, ir_ld;
    logic [7:0] d_addr;
    logic       d_wr, rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra, rb;
    logic [2:0] alu;
    logic       halted;
    logic [3:0] st;
  } outs_t;

  outs_t obs;
  always_comb obs = {PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
                     RF_Ra_Addr, RF_Rb_Addr, ALU_s, Halted, State};

  int n_cmp = 0;
  int n_fail = 0;

  // Output table per state code, straight from the instruction field definitions.
  function automatic outs_t exp_out(input logic [3:0] s, input logic [15:0] ir, input logic go);
    outs_t e;
    e = '0;
    e.st = s;
    case (s)
      4'd0: e.pc_clr = 1'b1;
      4'd1: begin e.ir_ld = go; e.pc_up = go; end
      4'd4, 4'd5: begin
        e.d_addr = ir[11:4]; e.rf_s = 1'b1; e.w_addr = ir[3:0]; e.w_en = (s == 4'd5);
      end
      4'd6: begin e.d_addr = ir[11:4]; e.ra = ir[3:0]; e.d_wr = 1'b1; end
      4'd7, 4'd8: begin
        e.ra = ir[11:8]; e.rb = ir[7:4]; e.w_addr = ir[3:0]; e.w_en = 1'b1;
        e.alu = (s == 4'd7) ? 3'b001 : 3'b010;
      end
      4'd9: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Cycles spent after FETCH: DECODE plus one execute cycle, LOAD takes two.
  function automatic int n_exec(input logic [15:0] ir);
    return (ir[15:12] == 4'd1) ? 3 : 2;
  endfunction

  function automatic logic [3:0] exec_state(input logic [15:0] ir, input int k);
    if (k == 0) return 4'd2;
    case (ir[15:12])
      4'd1:    return (k == 1) ? 4'd4 : 4'd5;
      4'd2:    return 4'd6;
      4'd3:    return 4'd7;
      4'd4:    return 4'd8;
      4'd5:    return 4'd9;
      default: return 4'd3;
    endcase
  endfunction

  task automatic test_instr(input logic [15:0] ir, input string tag);
    outs_t e;
    logic [3:0] s, nx;
    int n;
    IR = ir;
    #1;
    e = exp_out(4'd1, ir, 1'b1);
    n_cmp++;
    if (obs !== e || NextState !== 4'd2) begin
      n_fail++;
      $display("FAIL %s fetch: got %h ns=%0d, expected %h ns=2", tag, obs, NextState, e);
    end
    n = n_exec(ir);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk); #1;
      s  = exec_state(ir, k);
      nx = (k == n - 1) ? ((ir[15:12] == 4'd5) ? 4'd9 : 4'd1) : exec_state(ir, k + 1);
      e  = exp_out(s, ir, 1'b0);
      n_cmp++;
      if (obs !== e || NextState !== nx) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h ns=%0d, expected %h ns=%0d", tag, k, obs, NextState, e, nx);
      end
    end
    if (ir[15:12] != 4'd5) begin
      @(negedge Clk); #1;
      e = exp_out(4'd1, ir, 1'b1);
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s return-to-fetch: got %h, expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    outs_t e;
    #1;
    n_cmp++;
    if (obs !== '0 || NextState !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h ns=%0d, expected 0 ns=0", obs, NextState);
    end
    @(negedge Clk); #1;
    n_cmp++;
    if (obs !== '0 || NextState !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_clocked: got %h ns=%0d, expected 0 ns=0", obs, NextState);
    end
    Reset = 1'b1;
    #1;
    e = exp_out(4'd0, IR, 1'b0);
    n_cmp++;
    if (obs !== e || NextState !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_init: got %h ns=%0d, expected %h ns=1", obs, NextState, e);
    end
    @(negedge Clk); #1;
    e = exp_out(4'd1, IR, 1'b1);
    n_cmp++;
    if (obs !== e || NextState !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_fetch: got %h ns=%0d, expected %h ns=2", obs, NextState, e);
    end
  endtask

  task automatic test_directed();
    test_instr(16'h3123, "add_3123");
    test_instr(16'h1A54, "load_1A54");
    test_instr(16'h2407, "store_2407");
    test_instr(16'h4F9C, "sub_4F9C");
    test_instr(16'hF000, "noop_F000");
    test_instr(16'h0ABC, "noop_0ABC");
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd5) op = 4'd6;
      test_instr({op, 12'($urandom)}, "random");
    end
  endtask

  task automatic test_step();
    outs_t e;
    int ld_cnt;
    StepEn = 1'b1;
    IR = {4'd3, 12'($urandom)};
    #1;
    e = exp_out(4'd1, IR, 1'b0);
    n_cmp++;
    if (obs !== e || NextState !== 4'd1) begin
      n_fail++;
      $display("FAIL step_idle: got %h ns=%0d, expected %h ns=1", obs, NextState, e);
    end
    // Held key: one fetch, two clock edges after the key rises.
    Step = 1'b1;
    ld_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk); #1;
      if (IR_Ld === 1'b1) ld_cnt++;
      if (c == 2) begin
        n_cmp++;
        if (IR_Ld !== 1'b1 || State !== 4'd1) begin
          n_fail++;
          $display("FAIL step_latency: got ir_ld=%b state=%0d, expected ir_ld=1 state=1", IR_Ld, State);
        end
      end
    end
    n_cmp++;
    if (ld_cnt != 1) begin
      n_fail++;
      $display("FAIL step_held_count: got %0d fetches, expected 1", ld_cnt);
    end
    Step = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    e = exp_out(4'd1, IR, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL step_release_idle: got %h, expected %h", obs, e);
    end
    // Re-press lands during LOAD_B and must be dropped.
    IR = {4'd1, 12'($urandom)};
    Step = 1'b1;
    ld_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk); #1;
      if (IR_Ld === 1'b1) ld_cnt++;
      if (c == 2) Step = 1'b0;
      if (c == 3) Step = 1'b1;
    end
    n_cmp++;
    if (ld_cnt != 1 || State !== 4'd1) begin
      n_fail++;
      $display("FAIL step_drop: got %0d fetches state=%0d, expected 1 fetch state=1", ld_cnt, State);
    end
    Step = 1'b0;
    StepEn = 1'b0;
  endtask

  task automatic test_reset_mid();
    outs_t e;
    IR = 16'h3123;
    @(negedge Clk); @(negedge Clk); #1;
    n_cmp++;
    if (State !== 4'd7) begin
      n_fail++;
      $display("FAIL midreset_in_add: got state %0d, expected 7", State);
    end
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0 || NextState !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_abort: got %h ns=%0d, expected 0 ns=0", obs, NextState);
    end
    @(negedge Clk); #1;
    Reset = 1'b1;
    #1;
    e = exp_out(4'd0, IR, 1'b0);
    n_cmp++;
    if (obs !== e || NextState !== 4'd1) begin
      n_fail++;
      $display("FAIL midreset_init: got %h ns=%0d, expected %h ns=1", obs, NextState, e);
    end
    @(negedge Clk); #1;
    e = exp_out(4'd1, IR, 1'b1);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midreset_fetch: got %h, expected %h", obs, e);
    end
  endtask

  task automatic test_halt();
    int bad;
    test_instr(16'h5000, "halt_5000");
    StepEn = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      Step = 1'($urandom_range(0, 1));
      @(negedge Clk); #1;
      if (obs !== exp_out(4'd9, IR, 1'b0) || NextState !== 4'd9) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_stays: got %0d bad cycles, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_step();
    test_reset_mid();
    test_directed();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
